round_sched: RTL and testbench
==============================

# round_sched

Sequencer and two-way arbiter for the shared rounder datapath (significand rounding followed by exponent adjust/overflow clamp). It accepts rounding jobs from two requesters (adder and multiplier pipes) with round-robin fairness and drives the rounder's start/control strobes. It collects the overflow result and returns a tagged completion on a valid/ready port. It also maintains a sticky overflow flag, a saturating overflow counter and a watchdog on the significand stage.

## Interface
Parameters:
- TAG_W, 4, width of per-job tag carried through to the result
- TMO, 16, watchdog limit in cycles spent in ROUND before abort (≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  2  job request, bit i = requester i
- req_ready  out  2  one-hot grant/accept; nonzero only in IDLE
- req_db  in  2  per-requester precision select (1 = double, 0 = single)
- req_ovfen  in  2  per-requester overflow-trap enable
- req_tag  in  2*TAG_W  per-requester tag, requester i at [i*TAG_W +: TAG_W]
- rnd_start  out  1  one-cycle pulse launching significand rounding
- rnd_db  out  1  latched precision of current job, stable from ROUND through OUT
- rnd_ovfen  out  1  latched trap enable of current job, same stability
- rnd_adj_en  out  1  one-cycle pulse; datapath latches adjusted exponent
- sig_done  in  1  significand stage complete; ignored outside ROUND
- ovf  in  1  overflow from exponent-adjust stage; sampled only in ADJ
- res_valid  out  1  completion valid
- res_ready  in  1  completion consumer ready
- res_src  out  1  requester index of completed job
- res_tag  out  TAG_W  tag of completed job
- res_ovf  out  1  overflow occurred on this job
- res_err  out  1  job aborted by watchdog
- trap  out  1  one-cycle pulse when ovf sampled 1 and job ovfen = 1
- ovf_flag  out  1  sticky overflow indicator
- ovf_cnt  out  8  saturating count of overflowed jobs
- flag_clr  in  1  clears ovf_flag and ovf_cnt

## Operation
- States: IDLE, ROUND, ADJ, OUT.
- IDLE:
  - req_ready = grant from rr_arb2, combinational from req_valid.
  - On accept (req_valid & req_ready), latch src, db, ovfen and tag; go to ROUND.
- Arbitration:
  - Single requester wins directly.
  - Both valid: winner = requester not granted last.
  - Pointer updates only on accept. After reset, requester 0 wins a tie.
- ROUND:
  - rnd_start = 1 in the first ROUND cycle only. Watchdog counter clears on entry.
  - sig_done = 1 → ADJ.
  - Counter reaches TMO-1 without sig_done → OUT with res_err = 1, res_ovf = 0, no trap.
  - sig_done in the same cycle as timeout: sig_done wins.
- ADJ (exactly one cycle):
  - rnd_adj_en = 1; sample ovf into res_ovf.
  - If ovf: set ovf_flag, increment ovf_cnt (saturates at 255), pulse trap if latched ovfen.
  - Go to OUT.
- OUT:
  - res_valid = 1; res_src/tag/ovf/err held stable.
  - res_ready = 1 → IDLE. No new job is accepted in the same cycle.
- flag_clr coinciding with an ADJ overflow: clear takes priority, result is flag = 0, cnt = 0.
- Reset values: state IDLE, all outputs 0 (ovf_cnt = 0, res_tag = 0), arbitration pointer favours requester 0, watchdog 0.
- Reset mid-job abandons the job. No res_valid or trap is issued for it.

## Timing
- Accept at cycle t.
- rnd_start at t+1.
- Earliest sig_done at t+2 (a sig_done in the rnd_start cycle is ignored).
- rnd_adj_en and trap one cycle after sig_done.
- res_valid the cycle after ADJ, so minimum t+4.
- Back-to-back: result handshake at cycle u → next accept earliest u+1.
- Throughput: one job per ≥5 cycles.
- res_valid, once asserted, must not drop or change payload until res_ready.

## Structure
- Package fpu_rnd_pkg holds:
  - state enum rs_state_t {IDLE, ROUND, ADJ, OUT}
  - OVF_CNT_W = 8
  - the default TMO constant
- Sub-module rr_arb2 holds the two-input round-robin arbiter: req[1:0], accept strobe, grant[1:0], internal pointer, same clk/rst.

## Test plan
- Single job: req_valid=01, db=1, tag=5, sig_done at t+2, ovf=0 → rnd_start t+1, rnd_adj_en t+3, res_valid t+4 with src=0, tag=5, ovf=0, err=0.
- Fairness: req_valid=11 held for 4 jobs → grants 0,1,0,1; tags returned in that order.
- Overflow/trap: job with ovfen=1, ovf=1 in ADJ → trap pulse 1 cycle, res_ovf=1, ovf_flag=1, ovf_cnt=1. Same with ovfen=0 → no trap, flag and cnt still update.
- Watchdog: TMO=16, sig_done never asserted → res_valid with err=1 exactly 16 cycles after rnd_start's ROUND entry + 1; no rnd_adj_en.
- Backpressure: res_ready low 10 cycles → payload stable, req_ready=00 throughout; release → next accept the following cycle.
- Reset mid-ROUND and counter saturation: rst during ROUND → all outputs 0 next cycle, requester 0 wins a subsequent tie. 256 overflowed jobs → ovf_cnt=255; flag_clr → 0.

Source files
------------

// File: rtl/fpu_rnd_pkg.sv
// Shared types and constants for the rounder sequencer.
package fpu_rnd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      ADJ   = 2'd2,
      OUT   = 2'd3
   } rs_state_t;

   localparam int unsigned OVF_CNT_W   = 8;
   localparam int unsigned TMO_DEFAULT = 16;

endpackage

// File: rtl/round_sched_arb.sv
// Two-input round-robin arbiter; the pointer remembers who to favour on the next tie.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);

   logic pref_q;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = pref_q ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   // Favour requester 1 next only if requester 0 just won.
   always_ff @(posedge clk) begin
      if (rst) begin
         pref_q <= 1'b0;
      end else if (accept) begin
         pref_q <= grant[0];
      end
   end

endmodule

// File: rtl/round_sched.sv
// Job sequencer for the shared rounder: arbitration, strobe generation,
// watchdog, tagged completion and overflow bookkeeping.
module round_sched
   import fpu_rnd_pkg::*;
#(
   parameter int unsigned TAG_W = 4,
   parameter int unsigned TMO   = TMO_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [1:0]           req_db,
   input  logic [1:0]           req_ovfen,
   input  logic [2*TAG_W-1:0]   req_tag,
   output logic                 rnd_start,
   output logic                 rnd_db,
   output logic                 rnd_ovfen,
   output logic                 rnd_adj_en,
   input  logic                 sig_done,
   input  logic                 ovf,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic                 res_src,
   output logic [TAG_W-1:0]     res_tag,
   output logic                 res_ovf,
   output logic                 res_err,
   output logic                 trap,
   output logic                 ovf_flag,
   output logic [OVF_CNT_W-1:0] ovf_cnt,
   input  logic                 flag_clr
);

   localparam int unsigned WD_W = $clog2(TMO);

   rs_state_t            state_q;
   logic [WD_W-1:0]      wd_q;
   logic                 src_q;
   logic                 db_q;
   logic                 ovfen_q;
   logic [TAG_W-1:0]     tag_q;
   logic                 start_q;
   logic                 adj_q;
   logic                 res_valid_q;
   logic                 res_ovf_q;
   logic                 res_err_q;
   logic                 flag_q;
   logic [OVF_CNT_W-1:0] cnt_q;

   logic [1:0] arb_req;
   logic [1:0] grant;
   logic       accept;
   logic       ovf_hit;

   assign arb_req = req_valid & {2{(state_q == IDLE) && !rst}};

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (arb_req),
      .accept (accept),
      .grant  (grant)
   );

   assign req_ready = grant;
   assign accept    = |(req_valid & grant);
   assign ovf_hit   = (state_q == ADJ) && ovf && !rst;
   assign trap      = ovf_hit && ovfen_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wd_q        <= '0;
         src_q       <= 1'b0;
         db_q        <= 1'b0;
         ovfen_q     <= 1'b0;
         tag_q       <= '0;
         start_q     <= 1'b0;
         adj_q       <= 1'b0;
         res_valid_q <= 1'b0;
         res_ovf_q   <= 1'b0;
         res_err_q   <= 1'b0;
         flag_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         start_q <= 1'b0;
         adj_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  src_q   <= grant[1];
                  db_q    <= grant[1] ? req_db[1] : req_db[0];
                  ovfen_q <= grant[1] ? req_ovfen[1] : req_ovfen[0];
                  tag_q   <= grant[1] ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
                  start_q <= 1'b1;
                  wd_q    <= '0;
                  state_q <= ROUND;
               end
            end
            // sig_done during the launch cycle is stale; a same-cycle timeout loses to sig_done.
            ROUND: begin
               if (sig_done && !start_q) begin
                  adj_q   <= 1'b1;
                  state_q <= ADJ;
               end else if (wd_q == WD_W'(TMO - 1)) begin
                  res_valid_q <= 1'b1;
                  res_err_q   <= 1'b1;
                  res_ovf_q   <= 1'b0;
                  state_q     <= OUT;
               end else begin
                  wd_q <= wd_q + WD_W'(1);
               end
            end
            ADJ: begin
               res_valid_q <= 1'b1;
               res_err_q   <= 1'b0;
               res_ovf_q   <= ovf;
               state_q     <= OUT;
            end
            OUT: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase

         // Clear beats a coincident overflow.
         if (flag_clr) begin
            flag_q <= 1'b0;
            cnt_q  <= '0;
         end else if (ovf_hit) begin
            flag_q <= 1'b1;
            if (cnt_q != '1) begin
               cnt_q <= cnt_q + OVF_CNT_W'(1);
            end
         end
      end
   end

   assign rnd_start  = start_q;
   assign rnd_db     = db_q;
   assign rnd_ovfen  = ovfen_q;
   assign rnd_adj_en = adj_q;
   assign res_valid  = res_valid_q;
   assign res_src    = src_q;
   assign res_tag    = tag_q;
   assign res_ovf    = res_ovf_q;
   assign res_err    = res_err_q;
   assign ovf_flag   = flag_q;
   assign ovf_cnt    = cnt_q;

endmodule

// File: tb/tb_round_sched.sv
// Self-checking bench for round_sched: directed scenarios plus randomized jobs
// checked against a cycle-offset reference model.
module tb_round_sched;

   localparam int TAG_W = 4;
   localparam int TMO   = 16;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic [1:0]         req_valid = '0;
   logic [1:0]         req_ready;
   logic [1:0]         req_db = '0;
   logic [1:0]         req_ovfen = '0;
   logic [2*TAG_W-1:0] req_tag = '0;
   logic               rnd_start, rnd_db, rnd_ovfen, rnd_adj_en;
   logic               sig_done = 1'b0;
   logic               ovf = 1'b0;
   logic               res_valid;
   logic               res_ready = 1'b0;
   logic               res_src;
   logic [TAG_W-1:0]   res_tag;
   logic               res_ovf, res_err, trap, ovf_flag;
   logic [7:0]         ovf_cnt;
   logic               flag_clr = 1'b0;

   round_sched #(.TAG_W(TAG_W), .TMO(TMO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_db(req_db), .req_ovfen(req_ovfen), .req_tag(req_tag),
      .rnd_start(rnd_start), .rnd_db(rnd_db), .rnd_ovfen(rnd_ovfen),
      .rnd_adj_en(rnd_adj_en), .sig_done(sig_done), .ovf(ovf),
      .res_valid(res_valid), .res_ready(res_ready), .res_src(res_src),
      .res_tag(res_tag), .res_ovf(res_ovf), .res_err(res_err), .trap(trap),
      .ovf_flag(ovf_flag), .ovf_cnt(ovf_cnt), .flag_clr(flag_clr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model state: last granted requester (-1 = none since reset), flag and count.
   int last_gnt = -1;
   int cnt_m    = 0;
   int flag_m   = 0;

   typedef struct {
      int ok; int acc; int src; int start_off; int nstart; int adj_off; int nadj;
      int res_off; int ntrap; int trap_off; int unstable; int ready_bad;
      int hs; int hs_n; int hs_cyc;
      logic [TAG_W-1:0] tag; logic ovf_r; logic err_r; logic src_r; logic db_r; logic oe_r;
   } obs_t;

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   function automatic int exp_src(input logic [1:0] v);
      if (v == 2'b01) return 0;
      if (v == 2'b10) return 1;
      return (last_gnt == 0) ? 1 : 0;
   endfunction

   function automatic int eff_sd(input int sd);
      return (sd < 1) ? 1 : sd;
   endfunction

   function automatic int job_normal(input int sd);
      return (sd >= 0 && 1 + eff_sd(sd) <= TMO) ? 1 : 0;
   endfunction

   // Drives one job from request to completion handshake and records what was observed.
   task automatic do_job(input logic [1:0] vld, input logic [1:0] db, input logic [1:0] oe,
                         input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1, input int sd,
                         input logic ovf_v, input int rdly, input logic clr, output obs_t o);
      int t, adjc;
      logic [8:0] snap;
      o.ok = 0; o.acc = -1; o.src = -1; o.start_off = -1; o.nstart = 0; o.adj_off = -1;
      o.nadj = 0; o.res_off = -1; o.ntrap = 0; o.trap_off = -1; o.unstable = 0;
      o.ready_bad = 0; o.hs = 0; o.hs_n = -1; o.hs_cyc = -1;
      o.tag = '0; o.ovf_r = 0; o.err_r = 0; o.src_r = 0; o.db_r = 0; o.oe_r = 0;
      snap = '0;
      req_db = db; req_ovfen = oe; req_tag = {t1, t0}; flag_clr = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         req_valid = vld; sig_done = 1'($urandom); ovf = 1'($urandom); res_ready = 1'($urandom);
         #1;
         if ((req_ready & vld) != 2'b00) begin
            o.ok = 1; o.src = req_ready[1] ? 1 : 0;
            break;
         end
      end
      if (o.ok == 0) return;
      t = cyc; o.acc = cyc;
      adjc = t + 2 + eff_sd(sd);
      for (int n = 1; n <= TMO + rdly + 12; n++) begin
         step();
         sig_done  = (sd >= 0 && n >= 1 + sd);
         ovf       = (cyc == adjc) ? ovf_v : 1'($urandom);
         flag_clr  = clr && (cyc == adjc);
         res_ready = (rdly == 0) || (o.res_off >= 0 && n >= o.res_off + rdly);
         #1;
         if (rnd_start) begin o.nstart++; if (o.start_off < 0) o.start_off = n; end
         if (rnd_adj_en) begin o.nadj++; if (o.adj_off < 0) o.adj_off = n; end
         if (trap) begin o.ntrap++; if (o.trap_off < 0) o.trap_off = n; end
         if (req_ready != 2'b00) o.ready_bad++;
         if (res_valid) begin
            if (o.res_off < 0) begin
               o.res_off = n; o.tag = res_tag; o.ovf_r = res_ovf; o.err_r = res_err;
               o.src_r = res_src; o.db_r = rnd_db; o.oe_r = rnd_ovfen;
               snap = {res_src, res_tag, res_ovf, res_err, rnd_db, rnd_ovfen};
            end else if ({res_src, res_tag, res_ovf, res_err, rnd_db, rnd_ovfen} !== snap) begin
               o.unstable++;
            end
            if (res_ready) begin o.hs = 1; o.hs_n = n; o.hs_cyc = cyc; break; end
         end
      end
   endtask

   task automatic apply_reset();
      step();
      rst = 1'b1; req_valid = '0; sig_done = 1'b0; ovf = 1'b0; res_ready = 1'b0; flag_clr = 1'b0;
      step();
      step();
      rst = 1'b0;
      last_gnt = -1; cnt_m = 0; flag_m = 0;
   endtask

   task automatic test_reset();
      step();
      rst = 1'b1; req_valid = '0;
      step();
      step();
      #1;
      checks++;
      if ({req_ready, rnd_start, rnd_db, rnd_ovfen, rnd_adj_en, res_valid, res_src, res_tag,
           res_ovf, res_err, trap, ovf_flag} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %b want all zero", {req_ready, rnd_start, rnd_db,
                  rnd_ovfen, rnd_adj_en, res_valid, res_src, res_tag, res_ovf, res_err, trap, ovf_flag});
      end
      checks++;
      if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", ovf_cnt); end
      rst = 1'b0;
      last_gnt = -1; cnt_m = 0; flag_m = 0;
   endtask

   task automatic test_single();
      obs_t o;
      do_job(2'b01, 2'b01, 2'b00, 4'd5, 4'd9, 0, 1'b0, 0, 1'b0, o);
      checks++; if (o.ok != 1) begin errors++; $display("FAIL single_accept got %0d want 1", o.ok); end
      checks++; if (o.src != 0) begin errors++; $display("FAIL single_src got %0d want 0", o.src); end
      checks++; if (o.start_off != 1 || o.nstart != 1) begin errors++; $display("FAIL single_start got off %0d n %0d want off 1 n 1", o.start_off, o.nstart); end
      checks++; if (o.adj_off != 3 || o.nadj != 1) begin errors++; $display("FAIL single_adj got off %0d n %0d want off 3 n 1", o.adj_off, o.nadj); end
      checks++; if (o.res_off != 4) begin errors++; $display("FAIL single_res_off got %0d want 4", o.res_off); end
      checks++; if ({o.src_r, o.tag, o.ovf_r, o.err_r, o.db_r} !== {1'b0, 4'd5, 1'b0, 1'b0, 1'b1}) begin
         errors++; $display("FAIL single_payload got src %0d tag %0d ovf %0d err %0d db %0d want 0 5 0 0 1", o.src_r, o.tag, o.ovf_r, o.err_r, o.db_r);
      end
      if (o.ok == 1) last_gnt = o.src;
   endtask

   task automatic test_fairness();
      obs_t o;
      logic [TAG_W-1:0] t0, t1;
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         t0 = TAG_W'($urandom); t1 = TAG_W'($urandom);
         do_job(2'b11, 2'($urandom), 2'b00, t0, t1, $urandom_range(0, 3), 1'b0, 0, 1'b0, o);
         checks++; if (o.src != k % 2) begin errors++; $display("FAIL fair_grant%0d got %0d want %0d", k, o.src, k % 2); end
         checks++; if (o.tag !== ((k % 2 == 1) ? t1 : t0)) begin errors++; $display("FAIL fair_tag%0d got %0d want %0d", k, o.tag, (k % 2 == 1) ? t1 : t0); end
         if (o.ok == 1) last_gnt = o.src;
      end
   endtask

   task automatic test_overflow();
      obs_t o;
      apply_reset();
      do_job(2'b01, 2'b00, 2'b01, 4'd3, 4'd0, 1, 1'b1, 0, 1'b0, o);
      checks++; if (o.ntrap != 1 || o.trap_off != o.adj_off || o.adj_off != 3) begin errors++; $display("FAIL trap_on got n %0d off %0d want n 1 off 3", o.ntrap, o.trap_off); end
      checks++; if ({o.ovf_r, o.err_r} !== 2'b10) begin errors++; $display("FAIL trap_on_res got ovf %0d err %0d want 1 0", o.ovf_r, o.err_r); end
      checks++; if (ovf_flag !== 1'b1 || ovf_cnt !== 8'd1) begin errors++; $display("FAIL trap_on_flag got %0d/%0d want 1/1", ovf_flag, ovf_cnt); end
      do_job(2'b10, 2'b00, 2'b01, 4'd0, 4'd7, 2, 1'b1, 0, 1'b0, o);
      checks++; if (o.ntrap != 0) begin errors++; $display("FAIL trap_off got %0d pulses want 0", o.ntrap); end
      checks++; if (o.ovf_r !== 1'b1 || ovf_flag !== 1'b1 || ovf_cnt !== 8'd2) begin errors++; $display("FAIL trap_off_flag got ovf %0d flag %0d cnt %0d want 1 1 2", o.ovf_r, ovf_flag, ovf_cnt); end
      last_gnt = 1; cnt_m = 2; flag_m = 1;
   endtask

   task automatic test_watchdog();
      obs_t o;
      do_job(2'b01, 2'b00, 2'b11, 4'd4, 4'd0, -1, 1'b1, 0, 1'b0, o);
      checks++; if (o.res_off != TMO + 1) begin errors++; $display("FAIL wd_res_off got %0d want %0d", o.res_off, TMO + 1); end
      checks++; if ({o.err_r, o.ovf_r} !== 2'b10 || o.nadj != 0 || o.ntrap != 0) begin errors++; $display("FAIL wd_payload got err %0d ovf %0d adj %0d trap %0d want 1 0 0 0", o.err_r, o.ovf_r, o.nadj, o.ntrap); end
      last_gnt = 0;
      do_job(2'b10, 2'b00, 2'b00, 4'd0, 4'd6, TMO - 1, 1'b0, 0, 1'b0, o);
      checks++; if (o.err_r !== 1'b0 || o.adj_off != TMO + 1) begin errors++; $display("FAIL wd_edge_done got err %0d adj %0d want 0 %0d", o.err_r, o.adj_off, TMO + 1); end
      last_gnt = 1;
      do_job(2'b01, 2'b00, 2'b00, 4'd2, 4'd0, TMO, 1'b0, 0, 1'b0, o);
      checks++; if (o.err_r !== 1'b1 || o.res_off != TMO + 1 || o.nadj != 0) begin errors++; $display("FAIL wd_late_done got err %0d res %0d adj %0d want 1 %0d 0", o.err_r, o.res_off, o.nadj, TMO + 1); end
      last_gnt = 0;
   endtask

   task automatic test_backpressure();
      obs_t o, o2;
      do_job(2'b11, 2'b10, 2'b00, 4'd1, 4'd12, 0, 1'b0, 10, 1'b0, o);
      checks++; if (o.src != 1 || o.tag !== 4'd12) begin errors++; $display("FAIL bp_grant got src %0d tag %0d want 1 12", o.src, o.tag); end
      checks++; if (o.unstable != 0 || o.ready_bad != 0) begin errors++; $display("FAIL bp_stable got changes %0d ready %0d want 0 0", o.unstable, o.ready_bad); end
      checks++; if (o.hs_n != o.res_off + 10 || o.res_off != 4) begin errors++; $display("FAIL bp_hold got hs %0d res %0d want %0d 4", o.hs_n, o.res_off, 14); end
      last_gnt = 1;
      do_job(2'b01, 2'b00, 2'b00, 4'd8, 4'd0, 0, 1'b0, 0, 1'b0, o2);
      checks++; if (o2.acc != o.hs_cyc + 1) begin errors++; $display("FAIL bp_next_accept got %0d want %0d", o2.acc, o.hs_cyc + 1); end
      last_gnt = 0;
   endtask

   task automatic test_reset_mid();
      obs_t o;
      apply_reset();
      do_job(2'b01, 2'b11, 2'b11, 4'd15, 4'd0, 0, 1'b1, 0, 1'b0, o);
      last_gnt = 0;
      step(); req_valid = 2'b01; sig_done = 1'b0; #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rmid_accept got %b want 01", req_ready); end
      step(); req_valid = 2'b00;
      step();
      step(); rst = 1'b1; sig_done = 1'b1; ovf = 1'b1;
      step(); rst = 1'b0; #1;
      checks++;
      if ({req_ready, rnd_start, rnd_db, rnd_ovfen, rnd_adj_en, res_valid, res_src, res_tag,
           res_ovf, res_err, trap, ovf_flag, ovf_cnt} !== '0) begin
         errors++;
         $display("FAIL rmid_outputs got %b want all zero", {req_ready, rnd_start, rnd_db, rnd_ovfen,
                  rnd_adj_en, res_valid, res_src, res_tag, res_ovf, res_err, trap, ovf_flag, ovf_cnt});
      end
      last_gnt = -1; cnt_m = 0; flag_m = 0;
      do_job(2'b11, 2'b00, 2'b00, 4'd10, 4'd11, 0, 1'b0, 0, 1'b0, o);
      checks++; if (o.src != 0 || o.nstart != 1) begin errors++; $display("FAIL rmid_tie got src %0d starts %0d want 0 1", o.src, o.nstart); end
      last_gnt = 0;
   endtask

   task automatic test_saturation();
      obs_t o;
      apply_reset();
      for (int k = 1; k <= 256; k++) begin
         do_job(2'($urandom_range(1, 3)), 2'b00, 2'b00, 4'd0, 4'd0, 0, 1'b1, 0, 1'b0, o);
         if (k == 255) begin
            checks++; if (ovf_cnt !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d want 255", ovf_cnt); end
         end
      end
      checks++; if (ovf_cnt !== 8'd255 || ovf_flag !== 1'b1) begin errors++; $display("FAIL sat_256 got %0d flag %0d want 255 1", ovf_cnt, ovf_flag); end
      step(); flag_clr = 1'b1;
      step(); flag_clr = 1'b0; #1;
      checks++; if (ovf_cnt !== 8'd0 || ovf_flag !== 1'b0) begin errors++; $display("FAIL sat_clr got %0d flag %0d want 0 0", ovf_cnt, ovf_flag); end
      do_job(2'b01, 2'b00, 2'b00, 4'd0, 4'd0, 0, 1'b1, 0, 1'b0, o);
      do_job(2'b01, 2'b00, 2'b01, 4'd0, 4'd0, 0, 1'b1, 0, 1'b1, o);
      checks++; if (ovf_cnt !== 8'd0 || ovf_flag !== 1'b0 || o.ntrap != 1) begin errors++; $display("FAIL clr_vs_ovf got cnt %0d flag %0d trap %0d want 0 0 1", ovf_cnt, ovf_flag, o.ntrap); end
      apply_reset();
   endtask

   task automatic test_random();
      obs_t o;
      logic [1:0] vld, db, oe;
      logic [TAG_W-1:0] t0, t1;
      logic ov, clr;
      int sd, r, rd, es, nm, eadj, eres;
      for (int k = 0; k < 40; k++) begin
         vld = 2'($urandom_range(1, 3)); db = 2'($urandom); oe = 2'($urandom);
         t0 = TAG_W'($urandom); t1 = TAG_W'($urandom); ov = 1'($urandom);
         clr = ($urandom_range(0, 7) == 0); rd = $urandom_range(0, 3);
         r = $urandom_range(0, 9);
         sd = (r < 7) ? $urandom_range(0, 4) : (r == 7) ? -1 : (r == 8) ? TMO - 1 : TMO;
         es = exp_src(vld); nm = job_normal(sd);
         eadj = 2 + eff_sd(sd); eres = nm ? eadj + 1 : TMO + 1;
         do_job(vld, db, oe, t0, t1, sd, ov, rd, clr, o);
         checks++; if (o.ok != 1 || o.src != es) begin errors++; $display("FAIL rnd%0d_grant got ok %0d src %0d want 1 %0d", k, o.ok, o.src, es); end
         if (o.ok != 1) continue;
         last_gnt = es;
         if (nm == 1) begin
            if (clr) begin cnt_m = 0; flag_m = 0; end
            else if (ov) begin flag_m = 1; cnt_m = (cnt_m < 255) ? cnt_m + 1 : 255; end
         end
         checks++; if (o.start_off != 1 || o.nstart != 1) begin errors++; $display("FAIL rnd%0d_start got off %0d n %0d want 1 1", k, o.start_off, o.nstart); end
         checks++; if (o.res_off != eres || o.hs_n != eres + rd) begin errors++; $display("FAIL rnd%0d_timing got res %0d hs %0d want %0d %0d", k, o.res_off, o.hs_n, eres, eres + rd); end
         checks++; if (o.nadj != nm || (nm == 1 && o.adj_off != eadj)) begin errors++; $display("FAIL rnd%0d_adj got n %0d off %0d want n %0d off %0d", k, o.nadj, o.adj_off, nm, eadj); end
         checks++;
         if ({o.src_r, o.tag, o.ovf_r, o.err_r, o.db_r, o.oe_r} !== {es[0], es ? t1 : t0, ov & nm[0], ~nm[0], db[es], oe[es]}) begin
            errors++; $display("FAIL rnd%0d_payload got %b want %b", k, {o.src_r, o.tag, o.ovf_r, o.err_r, o.db_r, o.oe_r}, {es[0], es ? t1 : t0, ov & nm[0], ~nm[0], db[es], oe[es]});
         end
         checks++; if (o.ntrap != int'(nm[0] & ov & oe[es])) begin errors++; $display("FAIL rnd%0d_trap got %0d want %0d", k, o.ntrap, nm[0] & ov & oe[es]); end
         checks++; if (o.unstable != 0 || o.ready_bad != 0) begin errors++; $display("FAIL rnd%0d_hold got changes %0d ready %0d want 0 0", k, o.unstable, o.ready_bad); end
         checks++; if (int'(ovf_cnt) != cnt_m || int'(ovf_flag) != flag_m) begin errors++; $display("FAIL rnd%0d_flag got cnt %0d flag %0d want %0d %0d", k, ovf_cnt, ovf_flag, cnt_m, flag_m); end
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL global_timeout reached time limit, want completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_overflow();
      test_watchdog();
      test_backpressure();
      test_reset_mid();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
